pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/fwd_unit.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and the forwarding compare used by the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Operand source for one EX source register; MEM result is newer than WB.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_m,
        input logic             we_m,
        input logic [REG_W-1:0] rd_w,
        input logic             we_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding compare for both source operands.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_M,
    input  logic       regwrite_M,
    input  logic [4:0] rd_W,
    input  logic       regwrite_W,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    fwd_sel_t w_sel_a;
    fwd_sel_t w_sel_b;

    // One compare per operand, same priority rules.
    assign w_sel_a = fwd_select(rs1_E, rd_M, regwrite_M, rd_W, regwrite_W);
    assign w_sel_b = fwd_select(rs2_E, rd_M, regwrite_M, rd_W, regwrite_W);

    assign fwd_a = w_sel_a;
    assign fwd_b = w_sel_b;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, forwarding
// select and data-memory handshake sequencing with timeout.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_E,
    input  logic             memread_E,
    input  logic             pcsrc_E,
    input  logic [4:0]       rd_M,
    input  logic             regwrite_M,
    input  logic             memread_M,
    input  logic             memwrite_M,
    input  logic [4:0]       rd_W,
    input  logic             regwrite_W,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             en_FD,
    output logic             en_DE,
    output logic             en_EM,
    output logic             en_MW,
    output logic             flush_FD,
    output logic             flush_DE,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t       r_state;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic       w_mem_acc;
    logic       w_wait_done;
    logic       w_release;
    logic       w_freeze;
    logic       w_load_use;
    logic       w_branch;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    fwd_unit u_fwd (
        .rs1_E      (rs1_E),
        .rs2_E      (rs2_E),
        .rd_M       (rd_M),
        .regwrite_M (regwrite_M),
        .rd_W       (rd_W),
        .regwrite_W (regwrite_W),
        .fwd_a      (w_fwd_a),
        .fwd_b      (w_fwd_b)
    );

    assign w_mem_acc   = memread_M | memwrite_M;
    assign w_wait_done = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign w_release   = (r_state == MEM_WAIT) && (dmem_ready || w_wait_done);
    assign w_load_use  = memread_E && (rd_E != 5'd0) &&
                         ((rd_E == rs1_D) || (rd_E == rs2_D));

    // Forwarding is independent of stalls but forced to register file in reset.
    assign fwd_a = rst ? 2'b00 : w_fwd_a;
    assign fwd_b = rst ? 2'b00 : w_fwd_b;

    // Enables, flushes and memory request; a pending access freezes everything.
    always_comb begin
        pc_en    = 1'b0;
        en_FD    = 1'b0;
        en_DE    = 1'b0;
        en_EM    = 1'b0;
        en_MW    = 1'b0;
        flush_FD = 1'b0;
        flush_DE = 1'b0;
        dmem_req = 1'b0;
        w_freeze = 1'b0;
        w_branch = 1'b0;
        if (!rst) begin
            if (r_state == RUN) begin
                dmem_req = w_mem_acc;
                w_freeze = w_mem_acc & ~dmem_ready;
            end else begin
                dmem_req = 1'b1;
                w_freeze = ~w_release;
            end
            if (!w_freeze) begin
                en_DE = 1'b1;
                en_EM = 1'b1;
                en_MW = 1'b1;
                if (pcsrc_E) begin
                    pc_en    = 1'b1;
                    en_FD    = 1'b1;
                    flush_FD = 1'b1;
                    flush_DE = 1'b1;
                    w_branch = 1'b1;
                end else if (w_load_use) begin
                    flush_DE = 1'b1;
                end else begin
                    pc_en = 1'b1;
                    en_FD = 1'b1;
                end
            end
        end
    end

    // Handshake state, wait/timeout tracking, sticky error and perf counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            mem_err    <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            if (r_state == RUN) begin
                if (w_mem_acc && !dmem_ready) begin
                    r_state    <= MEM_WAIT;
                    r_wait_cnt <= WAIT_W'(1);
                end
            end else begin
                if (w_release) begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                    if (!dmem_ready) begin
                        mem_err <= 1'b1;
                    end
                end else begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
            end
            if (!pc_en) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (w_branch) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1_D;
        logic [4:0] rs2_D;
        logic [4:0] rs1_E;
        logic [4:0] rs2_E;
        logic [4:0] rd_E;
        logic       memread_E;
        logic       pcsrc_E;
        logic [4:0] rd_M;
        logic       regwrite_M;
        logic       memread_M;
        logic       memwrite_M;
        logic [4:0] rd_W;
        logic       regwrite_W;
        logic       dmem_ready;
    } in_t;

    // {pc_en,en_FD,en_DE,en_EM,en_MW,flush_FD,flush_DE,dmem_req}, fwd_a, fwd_b
    typedef struct packed {
        logic [7:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  e;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    localparam logic [7:0] C_RUN    = 8'b11111_00_0;
    localparam logic [7:0] C_RUNREQ = 8'b11111_00_1;
    localparam logic [7:0] C_FRZ    = 8'b00000_00_1;
    localparam logic [7:0] C_LU     = 8'b00111_01_0;
    localparam logic [7:0] C_BR     = 8'b11111_11_0;
    localparam logic [7:0] C_BRREQ  = 8'b11111_11_1;
    localparam logic [7:0] C_ZERO   = 8'b00000_00_0;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic        memread_E, pcsrc_E, regwrite_M, memread_M, memwrite_M;
    logic        regwrite_W, dmem_ready;
    logic        pc_en, en_FD, en_DE, en_EM, en_MW, flush_FD, flush_DE;
    logic [1:0]  fwd_a, fwd_b;
    logic        dmem_req, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    int   n_checks = 0;
    int   n_err    = 0;
    vec_t tbl[$];
    sb_t  sb[$];

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_D      (rs1_D),
        .rs2_D      (rs2_D),
        .rs1_E      (rs1_E),
        .rs2_E      (rs2_E),
        .rd_E       (rd_E),
        .memread_E  (memread_E),
        .pcsrc_E    (pcsrc_E),
        .rd_M       (rd_M),
        .regwrite_M (regwrite_M),
        .memread_M  (memread_M),
        .memwrite_M (memwrite_M),
        .rd_W       (rd_W),
        .regwrite_W (regwrite_W),
        .dmem_ready (dmem_ready),
        .pc_en      (pc_en),
        .en_FD      (en_FD),
        .en_DE      (en_DE),
        .en_EM      (en_EM),
        .en_MW      (en_MW),
        .flush_FD   (flush_FD),
        .flush_DE   (flush_DE),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .dmem_req   (dmem_req),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [7:0] c, input logic [1:0] fa, input logic [1:0] fb);
        out_t o;
        o.ctl = c;
        o.fa  = fa;
        o.fb  = fb;
        return o;
    endfunction

    task automatic add(input string name, input in_t i, input out_t e);
        vec_t v;
        v.name = name;
        v.i    = i;
        v.e    = e;
        tbl.push_back(v);
    endtask

    // Drive one cycle after the edge, queue its expectation, compare mid-cycle.
    task automatic step(input string name, input in_t v, input out_t e);
        sb_t  s;
        out_t act;
        @(posedge clk);
        #1;
        rst        = v.rst;
        rs1_D      = v.rs1_D;
        rs2_D      = v.rs2_D;
        rs1_E      = v.rs1_E;
        rs2_E      = v.rs2_E;
        rd_E       = v.rd_E;
        memread_E  = v.memread_E;
        pcsrc_E    = v.pcsrc_E;
        rd_M       = v.rd_M;
        regwrite_M = v.regwrite_M;
        memread_M  = v.memread_M;
        memwrite_M = v.memwrite_M;
        rd_W       = v.rd_W;
        regwrite_W = v.regwrite_W;
        dmem_ready = v.dmem_ready;
        s.name = name;
        s.exp  = e;
        sb.push_back(s);
        @(negedge clk);
        s = sb.pop_front();
        act.ctl = {pc_en, en_FD, en_DE, en_EM, en_MW, flush_FD, flush_DE, dmem_req};
        act.fa  = fwd_a;
        act.fb  = fwd_b;
        n_checks++;
        if (act !== s.exp) begin
            n_err++;
            $display("FAIL %s: got en/flush/req=%b fwd_a=%b fwd_b=%b, expected en/flush/req=%b fwd_a=%b fwd_b=%b",
                     s.name, act.ctl, act.fa, act.fb, s.exp.ctl, s.exp.fa, s.exp.fb);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        in_t v;
        v = '0;
        v.rst        = 1'b1;
        v.memread_M  = 1'b1;
        v.pcsrc_E    = 1'b1;
        v.rs1_E      = 5'd3;
        v.rd_M       = 5'd3;
        v.regwrite_M = 1'b1;
        step({tag, "_rst0"}, v, mk(C_ZERO, 2'b00, 2'b00));
        step({tag, "_rst1"}, v, mk(C_ZERO, 2'b00, 2'b00));
        v = '0;
        step({tag, "_idle"}, v, mk(C_RUN, 2'b00, 2'b00));
        chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
        chk({tag, "_flush_cnt"}, flush_cnt, 32'd0);
        chk({tag, "_mem_err"}, {31'd0, mem_err}, 32'd0);
    endtask

    initial begin
        in_t v;
        in_t idle;
        idle = '0;
        rst = 1'b1;
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
        {memread_E, pcsrc_E, regwrite_M, memread_M, memwrite_M, regwrite_W, dmem_ready} = '0;

        do_reset("init");

        // Single-cycle vectors in RUN
        add("idle", idle, mk(C_RUN, 2'b00, 2'b00));
        v = '0; v.rs1_E = 5'd3; v.rd_M = 5'd3; v.regwrite_M = 1'b1; v.rd_W = 5'd3; v.regwrite_W = 1'b1;
        add("fwd_a_mem", v, mk(C_RUN, 2'b10, 2'b00));
        v.rd_M = 5'd0;
        add("fwd_a_wb", v, mk(C_RUN, 2'b01, 2'b00));
        v.rs1_E = 5'd0; v.rd_M = 5'd3;
        add("fwd_a_rf", v, mk(C_RUN, 2'b00, 2'b00));
        v = '0; v.rs2_E = 5'd7; v.rd_W = 5'd7; v.regwrite_W = 1'b1; v.rd_M = 5'd7;
        add("fwd_b_wb_noweM", v, mk(C_RUN, 2'b00, 2'b01));
        v.rs1_E = 5'd7; v.regwrite_M = 1'b1;
        add("fwd_ab_mem", v, mk(C_RUN, 2'b10, 2'b10));
        v = '0; v.regwrite_W = 1'b1; v.rs2_E = 5'd9; v.rd_M = 5'd9; v.regwrite_M = 1'b1;
        add("fwd_x0_wb", v, mk(C_RUN, 2'b00, 2'b10));
        v = '0; v.memread_E = 1'b1; v.rd_E = 5'd5; v.rs1_D = 5'd5;
        add("lu_rs1", v, mk(C_LU, 2'b00, 2'b00));
        v.rs1_D = 5'd1; v.rs2_D = 5'd5;
        add("lu_rs2", v, mk(C_LU, 2'b00, 2'b00));
        v = '0; v.memread_E = 1'b1;
        add("lu_x0", v, mk(C_RUN, 2'b00, 2'b00));
        v = '0; v.rd_E = 5'd5; v.rs1_D = 5'd5;
        add("lu_noload", v, mk(C_RUN, 2'b00, 2'b00));
        v.memread_E = 1'b1; v.pcsrc_E = 1'b1;
        add("br_over_lu", v, mk(C_BR, 2'b00, 2'b00));
        v = '0; v.memread_M = 1'b1; v.dmem_ready = 1'b1;
        add("mem_1cyc", v, mk(C_RUNREQ, 2'b00, 2'b00));
        v = '0; v.memwrite_M = 1'b1; v.dmem_ready = 1'b1; v.pcsrc_E = 1'b1;
        add("mem_1cyc_br", v, mk(C_BRREQ, 2'b00, 2'b00));

        foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].e);
        step("tbl_end", idle, mk(C_RUN, 2'b00, 2'b00));
        chk("tbl_stall_cnt", stall_cnt, 32'd2);
        chk("tbl_flush_cnt", flush_cnt, 32'd2);

        // Load-use alone, then branch coinciding with load-use
        do_reset("lu");
        v = '0; v.memread_E = 1'b1; v.rd_E = 5'd5; v.rs1_D = 5'd5;
        step("lu_seq", v, mk(C_LU, 2'b00, 2'b00));
        step("lu_after", idle, mk(C_RUN, 2'b00, 2'b00));
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        v.pcsrc_E = 1'b1;
        step("br_seq", v, mk(C_BR, 2'b00, 2'b00));
        step("br_after", idle, mk(C_RUN, 2'b00, 2'b00));
        chk("br_flush_cnt", flush_cnt, 32'd1);
        chk("br_stall_cnt", stall_cnt, 32'd1);

        // Memory wait: ready low three cycles, then high
        do_reset("mw");
        v = '0; v.memwrite_M = 1'b1;
        step("mw_run_frz", v, mk(C_FRZ, 2'b00, 2'b00));
        v.pcsrc_E = 1'b1;
        step("mw_wait1_br_held", v, mk(C_FRZ, 2'b00, 2'b00));
        v.pcsrc_E = 1'b0; v.memread_E = 1'b1; v.rd_E = 5'd5; v.rs1_D = 5'd5;
        step("mw_wait2_lu_held", v, mk(C_FRZ, 2'b00, 2'b00));
        v = '0; v.memwrite_M = 1'b1; v.dmem_ready = 1'b1;
        step("mw_release", v, mk(C_RUNREQ, 2'b00, 2'b00));
        step("mw_after", idle, mk(C_RUN, 2'b00, 2'b00));
        chk("mw_stall_cnt", stall_cnt, 32'd3);
        chk("mw_flush_cnt", flush_cnt, 32'd0);
        chk("mw_mem_err", {31'd0, mem_err}, 32'd0);

        // Timeout: ready never comes; release on wait count 4 with a pending branch
        v = '0; v.memread_M = 1'b1;
        step("to_run_frz", v, mk(C_FRZ, 2'b00, 2'b00));
        step("to_wait1", v, mk(C_FRZ, 2'b00, 2'b00));
        step("to_wait2", v, mk(C_FRZ, 2'b00, 2'b00));
        step("to_wait3", v, mk(C_FRZ, 2'b00, 2'b00));
        v.pcsrc_E = 1'b1;
        step("to_release_br", v, mk(C_BRREQ, 2'b00, 2'b00));
        step("to_after", idle, mk(C_RUN, 2'b00, 2'b00));
        chk("to_mem_err", {31'd0, mem_err}, 32'd1);
        chk("to_stall_cnt", stall_cnt, 32'd7);
        chk("to_flush_cnt", flush_cnt, 32'd1);
        step("to_idle1", idle, mk(C_RUN, 2'b00, 2'b00));
        step("to_idle2", idle, mk(C_RUN, 2'b00, 2'b00));
        chk("to_mem_err_sticky", {31'd0, mem_err}, 32'd1);

        // Reset asserted on the second wait cycle
        v = '0; v.memread_M = 1'b1;
        step("rw_run_frz", v, mk(C_FRZ, 2'b00, 2'b00));
        step("rw_wait1", v, mk(C_FRZ, 2'b00, 2'b00));
        v.rst = 1'b1;
        step("rw_wait2_rst", v, mk(C_ZERO, 2'b00, 2'b00));
        step("rw_run_idle", idle, mk(C_RUN, 2'b00, 2'b00));
        chk("rw_stall_cnt", stall_cnt, 32'd0);
        chk("rw_flush_cnt", flush_cnt, 32'd0);
        chk("rw_mem_err", {31'd0, mem_err}, 32'd0);
        v = '0; v.memread_M = 1'b1; v.dmem_ready = 1'b1;
        step("rw_run_1cyc", v, mk(C_RUNREQ, 2'b00, 2'b00));

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
